dmem_arbiter: RTL

- Shares one synchronous-read data BRAM (1-cycle read latency) between two requesters: the core memory stage (port C) and the DMA/bootloader engine (port D).
- Per accepted request it generates byte write enables and aligned store data, and tracks the in-flight read.
- Returned loads are extracted and sign/zero-extended per func3 and routed to the owning port.
- Port C has priority; a starvation counter guarantees port D forward progress.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arbiter_store_align.sv | 34 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 encodings, port
// ownership encoding and the layout of the one-stage response register.
package dmem_arbiter_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int FUNC3_BITS = 3;
  localparam int LANE_BITS  = 2;

  typedef struct packed {
    logic                  valid;
    logic                  owner;
    logic                  we;
    logic [FUNC3_BITS-1:0] func3;
    logic [LANE_BITS-1:0]  addr_lo;
    logic                  err;
  } resp_reg_t;

endpackage

// File: rtl/dmem_arbiter_store_align.sv
// Store lane steering: byte write enables, lane-replicated write data and
// the misalignment flag for a byte/half/word access of the given size.
module dmem_arbiter_store_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  we,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  always_comb begin
    we         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (size)
      2'b00: begin
        we        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        we         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      2'b10: begin
        we         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a 1-cycle-latency data BRAM: core port C has
// priority, a starvation counter forces a grant to DMA port D.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [2:0]        c_req_func3,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DWIDTH-1:0] c_req_wdata,
  output logic              c_resp_valid,
  output logic [DWIDTH-1:0] c_resp_rdata,
  output logic              c_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [2:0]        d_req_func3,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DWIDTH-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DWIDTH-1:0] d_resp_rdata,
  output logic              d_resp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  logic              sel_d, c_xfer, d_xfer, xfer;
  logic              force_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              f3_legal, req_err, sa_mis;
  logic [3:0]        sa_we;
  logic [DWIDTH-1:0] sa_wdata;
  resp_reg_t         rsp;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DWIDTH-1:0] ext;

  // Handshake: a request transfers on the cycle valid & ready are both high;
  // only the grant winner sees ready, and the loser must hold its request.
  assign sel_d       = force_d ? d_req_valid : ~c_req_valid;
  assign c_req_ready = rst_n & c_req_valid & ~sel_d;
  assign d_req_ready = rst_n & d_req_valid & sel_d;
  assign c_xfer      = c_req_valid & c_req_ready;
  assign d_xfer      = d_req_valid & d_req_ready;
  assign xfer        = c_xfer | d_xfer;

  assign req_we    = sel_d ? d_req_we    : c_req_we;
  assign req_func3 = sel_d ? d_req_func3 : c_req_func3;
  assign req_addr  = sel_d ? d_req_addr  : c_req_addr;
  assign req_wdata = sel_d ? d_req_wdata : c_req_wdata;

  assign f3_legal = (req_func3 == F3_B) || (req_func3 == F3_H) || (req_func3 == F3_W) ||
                    (!req_we && ((req_func3 == F3_BU) || (req_func3 == F3_HU)));

  dmem_arbiter_store_align u_store_align (
    .size       (req_func3[1:0]),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .we         (sa_we),
    .wdata_rep  (sa_wdata),
    .misaligned (sa_mis)
  );

  assign req_err   = ~f3_legal | sa_mis;
  assign mem_en    = xfer & ~req_err;
  assign mem_we    = (mem_en & req_we) ? sa_we : 4'b0000;
  assign mem_addr  = req_addr[ADDR_W-1:2];
  assign mem_wdata = sa_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      force_d    <= 1'b0;
    end else begin
      if (d_xfer || !d_req_valid)
        starve_cnt <= '0;
      else if (starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
      // force_d takes effect the cycle after the counter saturates
      if (d_xfer)
        force_d <= 1'b0;
      else if ((STARVE_LIMIT != 0) && (starve_cnt == LIM))
        force_d <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp <= '0;
    end else begin
      rsp <= '{valid:   xfer,
               owner:   sel_d ? OWNER_D : OWNER_C,
               we:      req_we,
               func3:   req_func3,
               addr_lo: req_addr[1:0],
               err:     req_err};
    end
  end

  assign lane_byte = mem_rdata[8*rsp.addr_lo +: 8];
  assign lane_half = rsp.addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ext = '0;
    case (rsp.func3)
      F3_B:    ext = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   ext = {24'h0, lane_byte};
      F3_H:    ext = {{16{lane_half[15]}}, lane_half};
      F3_HU:   ext = {16'h0, lane_half};
      F3_W:    ext = mem_rdata;
      default: ext = '0;
    endcase
    if (rsp.we || rsp.err) ext = '0;
  end

  assign c_resp_valid = rsp.valid & (rsp.owner == OWNER_C);
  assign d_resp_valid = rsp.valid & (rsp.owner == OWNER_D);
  assign c_resp_rdata = c_resp_valid ? ext : '0;
  assign d_resp_rdata = d_resp_valid ? ext : '0;
  assign c_resp_err   = c_resp_valid & rsp.err;
  assign d_resp_err   = d_resp_valid & rsp.err;

endmodule
